// File: rtl/mesh_pkg.sv
// Shared packet definitions for the mesh network interface.
// Packets are MSB-first vectors [0:PL-1]: bit 0 is the valid flag, followed by
// dest X, dest Y, src X, src Y and the payload. An all-zero word is idle.
package mesh_pkg;

    localparam int PL = 32;
    localparam int CS = 2;
    localparam int DW = PL - 1 - 4 * CS;

    localparam int DEF_TX_DEPTH = 4;
    localparam int DEF_RX_DEPTH = 4;

    localparam int OFS_VALID  = 0;
    localparam int OFS_DEST_X = 1;
    localparam int OFS_DEST_Y = OFS_DEST_X + CS;
    localparam int OFS_SRC_X  = OFS_DEST_Y + CS;
    localparam int OFS_SRC_Y  = OFS_SRC_X + CS;
    localparam int OFS_DATA   = OFS_SRC_Y + CS;

    typedef logic [0:PL-1] pkt_t;
    typedef logic [CS-1:0] coord_t;
    typedef logic [DW-1:0] data_t;

    // Member order matches the wire order, so a static cast maps bit 0 to valid.
    typedef struct packed {
        logic   valid;
        coord_t dest_x;
        coord_t dest_y;
        coord_t src_x;
        coord_t src_y;
        data_t  data;
    } pkt_fields_t;

    // What the RX buffer keeps: dest is already checked and valid is implied.
    typedef struct packed {
        coord_t src_x;
        coord_t src_y;
        data_t  data;
    } rx_entry_t;

    localparam int RXW = $bits(rx_entry_t);

    function automatic pkt_t pack_pkt(coord_t dest_x, coord_t dest_y,
                                      coord_t src_x, coord_t src_y, data_t data);
        pkt_fields_t f;
        f.valid  = 1'b1;
        f.dest_x = dest_x;
        f.dest_y = dest_y;
        f.src_x  = src_x;
        f.src_y  = src_y;
        f.data   = data;
        return pkt_t'(f);
    endfunction

    function automatic pkt_fields_t unpack_pkt(pkt_t p);
        return pkt_fields_t'(p);
    endfunction

endpackage

// File: rtl/mesh_net_iface_if.sv
// Bundle of the core-side and router-side signals of the network interface.
// slave is the interface block itself; master is the core/router environment.
interface mesh_net_iface_if;
    import mesh_pkg::*;

    coord_t node_x;
    coord_t node_y;

    logic   tx_valid;
    logic   tx_ready;
    coord_t tx_dest_x;
    coord_t tx_dest_y;
    data_t  tx_data;

    pkt_t   pkt_out;
    logic   avail_in;

    pkt_t   pkt_in;
    logic   avail_out;

    logic   rx_valid;
    logic   rx_ready;
    coord_t rx_src_x;
    coord_t rx_src_y;
    data_t  rx_data;

    logic   err_overflow;
    logic   err_misroute;

    modport slave (
        input  node_x, node_y,
        input  tx_valid, tx_dest_x, tx_dest_y, tx_data,
        output tx_ready,
        output pkt_out,
        input  avail_in,
        input  pkt_in,
        output avail_out,
        output rx_valid, rx_src_x, rx_src_y, rx_data,
        input  rx_ready,
        output err_overflow, err_misroute
    );

    modport master (
        output node_x, node_y,
        output tx_valid, tx_dest_x, tx_dest_y, tx_data,
        input  tx_ready,
        input  pkt_out,
        output avail_in,
        output pkt_in,
        input  avail_out,
        input  rx_valid, rx_src_x, rx_src_y, rx_data,
        output rx_ready,
        input  err_overflow, err_misroute
    );

endinterface

// File: rtl/mesh_sync_fifo.sv
// Synchronous FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only when a pop
// happens in the same cycle; the read data is the head, combinationally.
module mesh_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Qualify the requests and compute next pointers and count.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mesh_net_iface.sv
// Network interface between a core and the local port of its mesh router.
// TX: core messages are packed with this node's coordinates, buffered, and
// injected as single-cycle packets when the router advertised room the cycle
// before. RX: router packets are checked against this node's address, buffered,
// and handed to the core; overflow and misroute are sticky until reset.
module mesh_net_iface
    import mesh_pkg::*;
#(
    parameter int TX_DEPTH = DEF_TX_DEPTH,
    parameter int RX_DEPTH = DEF_RX_DEPTH
) (
    input logic              clk,
    input logic              rst,
    mesh_net_iface_if.slave  bus
);

    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam logic [RCW:0] RX_LIMIT = (RCW + 1)'(RX_DEPTH);

    // TX path
    pkt_t   tx_wdata;
    pkt_t   tx_head;
    logic   tx_push, tx_pop;
    logic   tx_full, tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count_unused;
    pkt_t   pkt_out_q, pkt_out_d;

    // RX path
    rx_entry_t rx_wdata;
    rx_entry_t rx_head;
    logic      rx_in_valid, dest_ok;
    logic      rx_push, rx_pop;
    logic      rx_full, rx_empty;
    logic [RCW-1:0] rx_count;
    logic [RCW:0]   rx_occ;
    logic      err_ovf_q, err_ovf_d;
    logic      err_mis_q, err_mis_d;

    assign tx_wdata = pack_pkt(bus.tx_dest_x, bus.tx_dest_y, bus.node_x, bus.node_y,
                               bus.tx_data);
    assign tx_push  = bus.tx_valid && !tx_full;
    // avail_in seen now guarantees the router takes what we drive next cycle.
    assign tx_pop   = bus.avail_in && !tx_empty;

    mesh_sync_fifo #(.W(PL), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count_unused)
    );

    // Present the popped head for exactly one cycle, idle word otherwise.
    always_comb begin
        pkt_out_d = '0;
        if (tx_pop) pkt_out_d = tx_head;
    end

    // Injection register toward the router.
    always_ff @(posedge clk) begin
        if (rst) pkt_out_q <= '0;
        else     pkt_out_q <= pkt_out_d;
    end

    assign bus.tx_ready = !tx_full;
    assign bus.pkt_out  = pkt_out_q;

    assign rx_in_valid = bus.pkt_in[OFS_VALID];
    assign dest_ok     = (bus.pkt_in[OFS_DEST_X +: CS] == bus.node_x) &&
                         (bus.pkt_in[OFS_DEST_Y +: CS] == bus.node_y);
    assign rx_wdata    = {bus.pkt_in[OFS_SRC_X +: CS], bus.pkt_in[OFS_SRC_Y +: CS],
                          bus.pkt_in[OFS_DATA +: DW]};
    assign rx_pop      = bus.rx_ready && !rx_empty;
    // A full buffer still takes a packet when the head leaves in the same cycle.
    assign rx_push     = rx_in_valid && dest_ok && (!rx_full || rx_pop);

    mesh_sync_fifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .wdata_i (rx_wdata),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Sticky error accumulation; a misrouted packet never counts as overflow.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_mis_d = err_mis_q;
        if (rx_in_valid && !dest_ok)                       err_mis_d = 1'b1;
        if (rx_in_valid && dest_ok && rx_full && !rx_pop)  err_ovf_d = 1'b1;
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_mis_q <= err_mis_d;
        end
    end

    // Availability counts the arriving packet but not a same-cycle pop, so it
    // may deassert one cycle early; it never promises room that is not there.
    assign rx_occ        = {1'b0, rx_count} + {{RCW{1'b0}}, rx_in_valid};
    assign bus.avail_out = (rx_occ < RX_LIMIT);

    assign bus.rx_valid     = !rx_empty;
    assign bus.rx_src_x     = rx_head.src_x;
    assign bus.rx_src_y     = rx_head.src_y;
    assign bus.rx_data      = rx_head.data;
    assign bus.err_overflow = err_ovf_q;
    assign bus.err_misroute = err_mis_q;

endmodule

// File: tb/tb_mesh_net_iface.sv
// Scoreboard bench for mesh_net_iface: a queue-based reference model updates
// on each rising edge and pushes expected packets; a monitor on the falling
// edge pops and compares whatever the DUT presents.
module tb_mesh_net_iface;
    import mesh_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mesh_net_iface_if ifc();

    mesh_net_iface dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    logic [0:31] tx_m[$];
    logic [0:31] rx_m[$];
    logic [0:31] exp_inj[$];
    logic [0:31] exp_rx[$];
    bit ovf_m = 0;
    bit mis_m = 0;
    bit mon_en = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFOs as queues, updated from the inputs seen at each edge.
    initial forever begin
        bit tpop, tpush, rpop, rwr;
        logic [0:31] p;
        @(posedge clk);
        if (rst) begin
            tx_m.delete();
            rx_m.delete();
            exp_inj.delete();
            exp_rx.delete();
            ovf_m = 0;
            mis_m = 0;
        end else begin
            tpop  = ifc.avail_in && (tx_m.size() > 0);
            tpush = ifc.tx_valid && (tx_m.size() < 4);
            if (tpop) exp_inj.push_back(tx_m.pop_front());
            if (tpush) tx_m.push_back({1'b1, ifc.tx_dest_x, ifc.tx_dest_y,
                                       ifc.node_x, ifc.node_y, ifc.tx_data});
            p    = ifc.pkt_in;
            rpop = ifc.rx_ready && (rx_m.size() > 0);
            rwr  = 0;
            if (p[0]) begin
                if (p[1:2] != ifc.node_x || p[3:4] != ifc.node_y) mis_m = 1;
                else if (rx_m.size() < 4 || rpop)                 rwr = 1;
                else                                              ovf_m = 1;
            end
            if (rpop) void'(rx_m.pop_front());
            if (rwr) begin
                rx_m.push_back(p);
                exp_rx.push_back(p);
            end
        end
    end

    // Monitor: compare DUT outputs against the model between edges.
    initial forever begin
        logic [0:31] h;
        @(negedge clk);
        if (mon_en) begin
            check("tx_ready", 32'(ifc.tx_ready), 32'(tx_m.size() < 4));
            check("avail_out", 32'(ifc.avail_out),
                  32'((rx_m.size() + int'(ifc.pkt_in[0])) < 4));
            check("rx_valid", 32'(ifc.rx_valid), 32'(rx_m.size() > 0));
            check("err_overflow", 32'(ifc.err_overflow), 32'(ovf_m));
            check("err_misroute", 32'(ifc.err_misroute), 32'(mis_m));
            if (ifc.pkt_out != '0) begin
                if (exp_inj.size() == 0) check("pkt_out_spurious", ifc.pkt_out, 0);
                else                     check("pkt_out", ifc.pkt_out, exp_inj.pop_front());
            end else if (exp_inj.size() != 0) begin
                check("pkt_out_missing", ifc.pkt_out, exp_inj.pop_front());
            end
            if (ifc.rx_valid) begin
                if (exp_rx.size() == 0) begin
                    check("rx_spurious", 32'(ifc.rx_valid), 0);
                end else begin
                    h = exp_rx[0];
                    check("rx_src", 32'({ifc.rx_src_x, ifc.rx_src_y}), 32'({h[5:6], h[7:8]}));
                    check("rx_data", 32'(ifc.rx_data), 32'(h[9:31]));
                    if (ifc.rx_ready) void'(exp_rx.pop_front());
                end
            end
        end
    end

    initial begin
        logic [1:0] dx, dy;
        ifc.node_x    = 2'd1;
        ifc.node_y    = 2'd2;
        ifc.tx_valid  = 1'b0;
        ifc.tx_dest_x = '0;
        ifc.tx_dest_y = '0;
        ifc.tx_data   = '0;
        ifc.avail_in  = 1'b0;
        ifc.pkt_in    = '0;
        ifc.rx_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        mon_en = 1;

        // Reset state
        check("rst_tx_ready", 32'(ifc.tx_ready), 1);
        check("rst_avail_out", 32'(ifc.avail_out), 1);
        check("rst_rx_valid", 32'(ifc.rx_valid), 0);
        check("rst_pkt_out", ifc.pkt_out, 0);
        check("rst_err_ovf", 32'(ifc.err_overflow), 0);
        check("rst_err_mis", 32'(ifc.err_misroute), 0);

        // Single message, minimum latency, one-cycle pulse
        ifc.avail_in  = 1'b1;
        ifc.tx_valid  = 1'b1;
        ifc.tx_dest_x = 2'd2;
        ifc.tx_dest_y = 2'd0;
        ifc.tx_data   = 23'h1ABCD;
        step();
        ifc.tx_valid = 1'b0;
        check("lat_early", ifc.pkt_out, 0);
        step();
        check("tx_pkt_fixed", ifc.pkt_out, {1'b1, 2'd2, 2'd0, 2'd1, 2'd2, 23'h1ABCD});
        step();
        check("tx_pulse_end", ifc.pkt_out, 0);

        // TX backpressure: five attempts into a four-deep FIFO
        ifc.avail_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.tx_valid  = 1'b1;
            ifc.tx_dest_x = 2'(i % 3);
            ifc.tx_dest_y = 2'((i + 1) % 3);
            ifc.tx_data   = 23'($urandom);
            step();
        end
        ifc.tx_valid = 1'b0;
        check("tx_full_ready", 32'(ifc.tx_ready), 0);
        check("tx_held", ifc.pkt_out, 0);
        ifc.avail_in = 1'b1;
        repeat (5) step();
        check("tx_ready_back", 32'(ifc.tx_ready), 1);
        check("tx_drained", ifc.pkt_out, 0);

        // RX fill with core stalled
        ifc.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.pkt_in = {1'b1, 2'd1, 2'd2, 2'(i % 3), 2'(i % 2), 23'(i * 111 + 5)};
            #1;
            check("avail_fill", 32'(ifc.avail_out), (i == 3) ? 0 : 1);
            step();
        end
        // Overflow: fifth packet dropped
        ifc.pkt_in = {1'b1, 2'd1, 2'd2, 2'd0, 2'd0, 23'h7FFFFF};
        step();
        ifc.pkt_in = '0;
        check("ovf_set", 32'(ifc.err_overflow), 1);
        check("ovf_head_src", 32'({ifc.rx_src_x, ifc.rx_src_y}), 0);
        check("ovf_head_data", 32'(ifc.rx_data), 5);
        ifc.rx_ready = 1'b1;
        repeat (5) step();
        ifc.rx_ready = 1'b0;
        check("ovf_sticky", 32'(ifc.err_overflow), 1);
        check("rx_empty_after", 32'(ifc.rx_valid), 0);

        // Misroute
        ifc.pkt_in = {1'b1, 2'd0, 2'd0, 2'd2, 2'd2, 23'h12345};
        step();
        ifc.pkt_in = '0;
        check("mis_set", 32'(ifc.err_misroute), 1);
        check("mis_no_enq", 32'(ifc.rx_valid), 0);

        // Random traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            ifc.tx_valid  = ($urandom_range(0, 99) < 50);
            ifc.tx_dest_x = 2'($urandom_range(0, 2));
            ifc.tx_dest_y = 2'($urandom_range(0, 2));
            ifc.tx_data   = 23'($urandom);
            ifc.avail_in  = ($urandom_range(0, 99) < 60);
            ifc.rx_ready  = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) < 40) begin
                if ($urandom_range(0, 99) < 90) begin
                    dx = 2'd1;
                    dy = 2'd2;
                end else begin
                    dx = 2'($urandom_range(0, 2));
                    dy = 2'($urandom_range(0, 2));
                end
                ifc.pkt_in = {1'b1, dx, dy, 2'($urandom_range(0, 2)),
                              2'($urandom_range(0, 2)), 23'($urandom)};
            end else begin
                ifc.pkt_in = '0;
            end
            rst = (c == 1500);
            step();
            if (c == 1500) begin
                rst = 1'b0;
                check("mid_rst_tx_ready", 32'(ifc.tx_ready), 1);
                check("mid_rst_rx_valid", 32'(ifc.rx_valid), 0);
                check("mid_rst_pkt_out", ifc.pkt_out, 0);
                check("mid_rst_err_ovf", 32'(ifc.err_overflow), 0);
                check("mid_rst_err_mis", 32'(ifc.err_misroute), 0);
            end
        end

        // Drain
        ifc.tx_valid = 1'b0;
        ifc.pkt_in   = '0;
        ifc.avail_in = 1'b1;
        ifc.rx_ready = 1'b1;
        repeat (10) step();
        check("final_rx_valid", 32'(ifc.rx_valid), 0);
        check("final_tx_ready", 32'(ifc.tx_ready), 1);
        check("final_pkt_out", ifc.pkt_out, 0);
        check("final_inj_left", 32'(exp_inj.size()), 0);
        check("final_rx_left", 32'(exp_rx.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
